// File: rtl/ping_pong_pkg.sv
// Shared encodings for the ping-pong model: player states, ball states, action levels.
package ping_pong_pkg;

  // Player state encoding; 2'b11 is illegal and simply held.
  localparam logic [1:0] HIT         = 2'd0;
  localparam logic [1:0] WAIT_GOING  = 2'd1;
  localparam logic [1:0] WAIT_COMING = 2'd2;

  // Ball state encoding; 2'b11 is illegal and simply held.
  localparam logic [1:0] TO_A        = 2'd0;
  localparam logic [1:0] TO_B        = 2'd1;
  localparam logic [1:0] OUT_OF_PLAY = 2'd2;

  // Player action level.
  localparam logic ACT_HIT  = 1'b1;
  localparam logic ACT_IDLE = 1'b0;

endpackage

// File: rtl/pp_player.sv
// One ping-pong player: HIT / WAIT_GOING / WAIT_COMING FSM with a bounded wait counter.
module pp_player
  import ping_pong_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       act_opp_i,
  input  logic       go_i,
  output logic [1:0] state_o,
  output logic       act_o
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q,  wcnt_d;

  // Next state: the opponent's hit pulls us into WAIT_COMING with a fresh counter;
  // WAIT_COMING ends on go or when the wait budget is used up.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      HIT: begin
        if (act_opp_i) begin
          state_d = WAIT_COMING;
          wcnt_d  = '0;
        end else begin
          state_d = WAIT_GOING;
        end
      end
      WAIT_GOING: begin
        if (act_opp_i) begin
          state_d = WAIT_COMING;
          wcnt_d  = '0;
        end
      end
      WAIT_COMING: begin
        if (go_i || (wcnt_q == WCNT_LAST)) state_d = HIT;
        else                               wcnt_d  = wcnt_q + WCNT_W'(1);
      end
      default: state_d = state_q;
    endcase
  end

  // State and counter registers with synchronous reset into HIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HIT;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign state_o = state_q;
  assign act_o   = (state_q == HIT) ? ACT_HIT : ACT_IDLE;

endmodule

// File: rtl/ping_pong_n.sv
// Two-player ping-pong model with NUM_BALLS balls in flight.
// Optional hit counters on hits_a / hits_b when PING_PONG_STATS_EN is defined.
module ping_pong_n
  import ping_pong_pkg::*;
#(
  parameter int                   NUM_BALLS = 2,
  parameter logic [NUM_BALLS-1:0] INIT_DIR  = 2'b10,
  parameter int                   MAX_WAIT  = 4,
  parameter int                   CNT_W     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               go_a,
  input  logic                               go_b,
  output logic                               act_a,
  output logic                               act_b,
  output logic [1:0]                         state_a,
  output logic [1:0]                         state_b,
  output logic [2*NUM_BALLS-1:0]             ball_state,
  output logic [$clog2(NUM_BALLS+1)-1:0]     balls_in_play,
  output logic                               all_out
`ifdef PING_PONG_STATS_EN
  ,
  output logic [CNT_W-1:0]                   hits_a,
  output logic [CNT_W-1:0]                   hits_b
`endif
);

  localparam int BIP_W = $clog2(NUM_BALLS + 1);

  logic [NUM_BALLS-1:0][1:0] ball_vec;
  logic [BIP_W-1:0]          bip;

  pp_player #(.MAX_WAIT(MAX_WAIT)) u_player_a (
    .clk       (clk),
    .reset     (reset),
    .act_opp_i (act_b),
    .go_i      (go_a),
    .state_o   (state_a),
    .act_o     (act_a)
  );

  pp_player #(.MAX_WAIT(MAX_WAIT)) u_player_b (
    .clk       (clk),
    .reset     (reset),
    .act_opp_i (act_a),
    .go_i      (go_b),
    .state_o   (state_b),
    .act_o     (act_b)
  );

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
    logic [1:0] ball_q, ball_d;

    // A hit returns a ball heading to the hitter; a lone hit from the far side loses it.
    always_comb begin
      ball_d = ball_q;
      case (ball_q)
        TO_A:    if (act_a) ball_d = TO_B; else if (act_b) ball_d = OUT_OF_PLAY;
        TO_B:    if (act_b) ball_d = TO_A; else if (act_a) ball_d = OUT_OF_PLAY;
        default: ball_d = ball_q;
      endcase
    end

    // Ball register; reset restores the configured launch direction.
    always_ff @(posedge clk) begin
      if (reset) ball_q <= INIT_DIR[i] ? TO_B : TO_A;
      else       ball_q <= ball_d;
    end

    assign ball_vec[i] = ball_q;
  end

  assign ball_state = ball_vec;

  // Popcount of balls still in play; an illegal encoding still counts as in play.
  always_comb begin
    bip = '0;
    for (int i = 0; i < NUM_BALLS; i++)
      if (ball_vec[i] != OUT_OF_PLAY) bip = bip + BIP_W'(1);
  end

  assign balls_in_play = bip;
  assign all_out       = (bip == '0);

`ifdef PING_PONG_STATS_EN
  logic [CNT_W-1:0] hits_a_q, hits_b_q;

  // Saturating counts of cycles spent hitting.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_a_q <= '0;
      hits_b_q <= '0;
    end else begin
      if (act_a && (hits_a_q != '1)) hits_a_q <= hits_a_q + CNT_W'(1);
      if (act_b && (hits_b_q != '1)) hits_b_q <= hits_b_q + CNT_W'(1);
    end
  end

  assign hits_a = hits_a_q;
  assign hits_b = hits_b_q;
`else
  // CNT_W only sizes the stats counters; this empty guard keeps it referenced here.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end
`endif

endmodule

// File: tb/tb_ping_pong_n.sv
// Directed bench for ping_pong_n: rally trace, wait limit, go handling, mid-rally reset,
// ball loss to all_out on a one-ball instance, and saturating hit counters when
// PING_PONG_STATS_EN is defined.
module tb_ping_pong_n;

  localparam logic [1:0] P_HIT = 2'd0, P_WG = 2'd1, P_WC = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic go_a, go_b, go1_a, go1_b;

  logic       act_a, act_b, all_out;
  logic [1:0] state_a, state_b;
  logic [3:0] ball_state;
  logic [1:0] bip;

  logic       u1_act_a, u1_act_b, u1_all_out;
  logic [1:0] u1_state_a, u1_state_b;
  logic [1:0] u1_ball;
  logic [0:0] u1_bip;

`ifdef PING_PONG_STATS_EN
  logic [2:0] hits_a, hits_b, u1_hits_a, u1_hits_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] prev_bip;

  always #5 clk = ~clk;

  ping_pong_n #(.NUM_BALLS(2), .INIT_DIR(2'b10), .MAX_WAIT(4), .CNT_W(3)) u0 (
    .clk(clk), .reset(reset), .go_a(go_a), .go_b(go_b),
    .act_a(act_a), .act_b(act_b), .state_a(state_a), .state_b(state_b),
    .ball_state(ball_state), .balls_in_play(bip), .all_out(all_out)
`ifdef PING_PONG_STATS_EN
    , .hits_a(hits_a), .hits_b(hits_b)
`endif
  );

  ping_pong_n #(.NUM_BALLS(1), .INIT_DIR(1'b0), .MAX_WAIT(2), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .go_a(go1_a), .go_b(go1_b),
    .act_a(u1_act_a), .act_b(u1_act_b), .state_a(u1_state_a), .state_b(u1_state_b),
    .ball_state(u1_ball), .balls_in_play(u1_bip), .all_out(u1_all_out)
`ifdef PING_PONG_STATS_EN
    , .hits_a(u1_hits_a), .hits_b(u1_hits_b)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then invariant checks on u0 a little after the edge.
  task automatic step();
    logic was_rst;
    logic to_a, to_b;
    was_rst = reset;
    @(posedge clk);
    #1;
    to_a = (ball_state[1:0] == 2'd0) || (ball_state[3:2] == 2'd0);
    to_b = (ball_state[1:0] == 2'd1) || (ball_state[3:2] == 2'd1);
    chk("inv_state_a_legal", {7'd0, state_a != 2'd3}, 8'd1);
    chk("inv_state_b_legal", {7'd0, state_b != 2'd3}, 8'd1);
    chk("inv_ball_legal", {7'd0, (ball_state[1:0] != 2'd3) && (ball_state[3:2] != 2'd3)}, 8'd1);
    chk("inv_wg_a", {7'd0, !((state_a == P_WG) && to_a)}, 8'd1);
    chk("inv_wg_b", {7'd0, !((state_b == P_WG) && to_b)}, 8'd1);
    if (!was_rst) chk("inv_bip_nonincr", {7'd0, bip <= prev_bip}, 8'd1);
    prev_bip = bip;
  endtask

  task automatic chk_u0(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [3:0] bs, input logic [1:0] nb);
    chk({tag, "_state_a"}, {6'd0, state_a}, {6'd0, sa});
    chk({tag, "_state_b"}, {6'd0, state_b}, {6'd0, sb});
    chk({tag, "_balls"},   {4'd0, ball_state}, {4'd0, bs});
    chk({tag, "_in_play"}, {6'd0, bip}, {6'd0, nb});
    chk({tag, "_act_a"},   {7'd0, act_a}, {7'd0, sa == P_HIT});
    chk({tag, "_act_b"},   {7'd0, act_b}, {7'd0, sb == P_HIT});
    chk({tag, "_all_out"}, {7'd0, all_out}, 8'd0);
  endtask

  initial begin
    reset = 1'b1; go_a = 1'b0; go_b = 1'b0; go1_a = 1'b0; go1_b = 1'b0;
    prev_bip = 2'd2;
    step(); step();
    // Reset values: ball1 TO_B, ball0 TO_A.
    chk_u0("reset", P_HIT, P_HIT, 4'b0100, 2'd2);
`ifdef PING_PONG_STATS_EN
    chk("reset_hits_a", {5'd0, hits_a}, 8'd0);
    chk("reset_hits_b", {5'd0, hits_b}, 8'd0);
`endif
    reset = 1'b0;
    step();                                    // both hit: balls swap
    chk_u0("e1", P_WC, P_WC, 4'b0001, 2'd2);
    go_a = 1'b1; step();
    chk_u0("e2", P_HIT, P_WC, 4'b0001, 2'd2);
    go_a = 1'b0; step();                       // lone A hit: ball0 lost, ball1 returned
    chk_u0("e3", P_WG, P_WC, 4'b0110, 2'd1);
    go_a = 1'b1; step();                       // go_a ignored in WAIT_GOING
    chk_u0("e4", P_WG, P_WC, 4'b0110, 2'd1);
    step();                                    // B forced out after 4 cycles in WAIT_COMING
    chk_u0("e5_forced", P_WG, P_HIT, 4'b0110, 2'd1);
    go_a = 1'b0; step();
    chk_u0("e6", P_WC, P_WG, 4'b0010, 2'd1);
    go_a = 1'b1; step();                       // go on first WAIT_COMING cycle
    chk_u0("e7_go_a", P_HIT, P_WG, 4'b0010, 2'd1);
    go_a = 1'b0; step();
    chk_u0("e8", P_WG, P_WC, 4'b0110, 2'd1);
    go_b = 1'b1; step();
    chk_u0("e9_go_b", P_WG, P_HIT, 4'b0110, 2'd1);
    go_b = 1'b0; step();
    chk_u0("e10", P_WC, P_WG, 4'b0010, 2'd1);
    reset = 1'b1; step();                      // mid-rally reset
    chk_u0("midreset", P_HIT, P_HIT, 4'b0100, 2'd2);
    chk("u1_reset_ball", {6'd0, u1_ball}, 8'd0);
    chk("u1_reset_all_out", {7'd0, u1_all_out}, 8'd0);
    reset = 1'b0;

    // One-ball instance, MAX_WAIT=2: lose the only ball.
    step();
    chk("u1_e1_ball", {6'd0, u1_ball}, 8'd1);
    chk("u1_e1_state_a", {6'd0, u1_state_a}, {6'd0, P_WC});
    go1_a = 1'b1; step();
    chk("u1_e2_state_a", {6'd0, u1_state_a}, {6'd0, P_HIT});
    chk("u1_e2_state_b", {6'd0, u1_state_b}, {6'd0, P_WC});
    go1_a = 1'b0; step();
    chk("u1_e3_ball", {6'd0, u1_ball}, 8'd2);
    chk("u1_e3_bip", {7'd0, u1_bip}, 8'd0);
    chk("u1_e3_all_out", {7'd0, u1_all_out}, 8'd1);
    chk("u1_e3_state_b_forced", {6'd0, u1_state_b}, {6'd0, P_HIT});
    step();
    chk("u1_e4_ball_absorb", {6'd0, u1_ball}, 8'd2);
    chk("u1_e4_all_out", {7'd0, u1_all_out}, 8'd1);

    // Continuous go on both sides: both players alternate HIT / WAIT_COMING together.
    reset = 1'b1; step();
    reset = 1'b0; go_a = 1'b1; go_b = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 1)  chk_u0("go_e1", P_WC, P_WC, 4'b0001, 2'd2);
      if (e == 2)  chk_u0("go_e2", P_HIT, P_HIT, 4'b0001, 2'd2);
      if (e == 17) chk_u0("go_e17", P_WC, P_WC, 4'b0001, 2'd2);
`ifdef PING_PONG_STATS_EN
      if (e == 1)  chk("hits_a_e1", {5'd0, hits_a}, 8'd1);
      if (e == 11) chk("hits_a_e11", {5'd0, hits_a}, 8'd6);
      if (e == 13) chk("hits_a_sat7", {5'd0, hits_a}, 8'd7);
      if (e == 17) chk("hits_a_hold7", {5'd0, hits_a}, 8'd7);
      if (e == 17) chk("hits_b_hold7", {5'd0, hits_b}, 8'd7);
`endif
    end
    go_a = 1'b0; go_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
